// File: rtl/dmem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for dmem_port_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          Req0;
    logic          Req1;
    logic          We0;
    logic          We1;
    logic [AW-1:0] Addr0;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData0;
    logic [DW-1:0] WData1;
    logic          Gnt0;
    logic          Gnt1;
    logic          Done0;
    logic          Done1;
    logic [DW-1:0] RData0;
    logic [DW-1:0] RData1;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWriteData;
    logic          MemRead;
    logic          MemWrite;
    logic [DW-1:0] MemReadData;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemReadData,
        output Gnt0, Gnt1, Done0, Done1, RData0, RData1,
               MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemReadData,
        input  Gnt0, Gnt1, Done0, Done1, RData0, RData1,
               MemAddress, MemWriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter/sequencer letting fetch (port 0) and LSU (port 1) share one
// data memory with MEM_LAT-cycle read latency; IDLE -> BUSY -> DONE per access.
module dmem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input logic             Clk,
    input logic             Reset,
    dmem_port_arbiter_if.slave bus
);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          last;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic grant_c;
    logic gsel_c;
    logic owner_c;
    logic we_c;

    logic gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, memread_nxt, memwrite_nxt;
    logic gnt0_q, gnt1_q, done0_q, done1_q, memread_q, memwrite_q;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and arbitration; ties go to the port not served last
    always_comb begin
        state_nxt = state;
        grant_c   = 1'b0;
        gsel_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    grant_c   = 1'b1;
                    gsel_c    = (bus.Req0 && bus.Req1) ? ~last : bus.Req1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: if (cnt == '0) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered strobes line up with it
    always_comb begin
        owner_c      = grant_c ? gsel_c : owner;
        we_c         = grant_c ? (gsel_c ? bus.We1 : bus.We0) : we_q;
        gnt0_nxt     = (state_nxt != S_IDLE) && !owner_c;
        gnt1_nxt     = (state_nxt != S_IDLE) &&  owner_c;
        done0_nxt    = (state_nxt == S_DONE) && !owner_c;
        done1_nxt    = (state_nxt == S_DONE) &&  owner_c;
        memread_nxt  = (state_nxt == S_BUSY) && !we_c;
        memwrite_nxt = grant_c && we_c;
    end

    // Access latches, latency counter and per-port read data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (grant_c) begin
            owner   <= gsel_c;
            last    <= gsel_c;
            cnt     <= CNT_INIT;
            we_q    <= gsel_c ? bus.We1    : bus.We0;
            addr_q  <= gsel_c ? bus.Addr1  : bus.Addr0;
            wdata_q <= gsel_c ? bus.WData1 : bus.WData0;
        end else if (state == S_BUSY) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else if (!we_q) begin
                if (owner) rdata1_q <= bus.MemReadData;
                else       rdata0_q <= bus.MemReadData;
            end
        end
    end

    // Registered handshake and memory strobes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            gnt0_q     <= gnt0_nxt;
            gnt1_q     <= gnt1_nxt;
            done0_q    <= done0_nxt;
            done1_q    <= done1_nxt;
            memread_q  <= memread_nxt;
            memwrite_q <= memwrite_nxt;
        end
    end

    assign bus.Gnt0         = gnt0_q;
    assign bus.Gnt1         = gnt1_q;
    assign bus.Done0        = done0_q;
    assign bus.Done1        = done1_q;
    assign bus.MemRead      = memread_q;
    assign bus.MemWrite     = memwrite_q;
    assign bus.MemAddress   = addr_q;
    assign bus.MemWriteData = wdata_q;
    assign bus.RData0       = rdata0_q;
    assign bus.RData1       = rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: drivers issue per-port requests, a
// monitor checks each Done against the expected queue and a latency-accurate memory.
module tb_dmem_port_arbiter;
    localparam int unsigned LAT = 2;
    localparam int MAXWAIT = 400;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          drop;
    } req_t;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] rdata;
    } exp_t;

    logic Clk;
    logic Reset;
    dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    req_t rq0[$];
    req_t rq1[$];
    exp_t exp_q[$];
    logic [31:0] mem [0:255];
    int rd_age;
    logic [31:0] rmodel [2];
    int gc, rc, wc;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory: data valid only LAT cycles after MemRead rises
    always @(posedge Clk) begin
        if (bus.MemWrite) mem[bus.MemAddress[9:2]] <= bus.MemWriteData;
        rd_age <= bus.MemRead ? rd_age + 1 : 0;
    end
    assign bus.MemReadData = (bus.MemRead && rd_age == int'(LAT) - 1) ?
                             mem[bus.MemAddress[9:2]] : 32'hBAD0_BAD0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Port 0 requester
    initial begin : drv0
        req_t r;
        bit active, drop;
        active = 0; drop = 0;
        bus.Req0 = 0; bus.We0 = 0; bus.Addr0 = '0; bus.WData0 = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                bus.Req0 = 0; active = 0;
            end else begin
                if (active && bus.Done0) begin active = 0; bus.Req0 = 0; end
                if (active && drop && bus.Gnt0) bus.Req0 = 0;
                if (!active && rq0.size() > 0) begin
                    r = rq0.pop_front();
                    bus.We0 = r.we; bus.Addr0 = r.addr; bus.WData0 = r.wdata;
                    bus.Req0 = 1; active = 1; drop = r.drop;
                end
            end
        end
    end

    // Port 1 requester
    initial begin : drv1
        req_t r;
        bit active, drop;
        active = 0; drop = 0;
        bus.Req1 = 0; bus.We1 = 0; bus.Addr1 = '0; bus.WData1 = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                bus.Req1 = 0; active = 0;
            end else begin
                if (active && bus.Done1) begin active = 0; bus.Req1 = 0; end
                if (active && drop && bus.Gnt1) bus.Req1 = 0;
                if (!active && rq1.size() > 0) begin
                    r = rq1.pop_front();
                    bus.We1 = r.we; bus.Addr1 = r.addr; bus.WData1 = r.wdata;
                    bus.Req1 = 1; active = 1; drop = r.drop;
                end
            end
        end
    end

    // Monitor: per-access strobe counts, completion order and read data
    always @(negedge Clk) begin
        exp_t e;
        int p;
        logic [31:0] rd;
        if (Reset) begin
            gc = 0; rc = 0; wc = 0;
            rmodel[0] = '0; rmodel[1] = '0;
        end else begin
            if (bus.Gnt0 || bus.Gnt1) gc++;
            if (bus.MemRead)  rc++;
            if (bus.MemWrite) wc++;
            chk(!(bus.Done0 && bus.Done1), "done_exclusive", {bus.Done0, bus.Done1}, 32'h0);
            if (bus.Done0 || bus.Done1) begin
                p  = bus.Done1 ? 1 : 0;
                rd = bus.Done1 ? bus.RData1 : bus.RData0;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 32'(p), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk(p == e.port, "done_port", 32'(p), 32'(e.port));
                    chk((bus.Done1 ? bus.Gnt1 : bus.Gnt0) == 1'b1, "gnt_at_done", 32'h0, 32'h1);
                    chk(gc == int'(LAT) + 1, "gnt_cycles", 32'(gc), 32'(LAT + 1));
                    chk(rc == (e.we ? 0 : int'(LAT)), "memread_cycles", 32'(rc), e.we ? 32'h0 : 32'(LAT));
                    chk(wc == (e.we ? 1 : 0), "memwrite_cycles", 32'(wc), e.we ? 32'h1 : 32'h0);
                    if (!e.we) rmodel[e.port] = e.rdata;
                    chk(rd == rmodel[p], "rdata", rd, rmodel[p]);
                end
                gc = 0; rc = 0; wc = 0;
            end else begin
                chk(bus.RData0 == rmodel[0], "rdata0_hold", bus.RData0, rmodel[0]);
                chk(bus.RData1 == rmodel[1], "rdata1_hold", bus.RData1, rmodel[1]);
            end
        end
    end

    task automatic push_req(input int p, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit drop);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.drop = drop;
        if (p == 0) rq0.push_back(r);
        else        rq1.push_back(r);
    endtask

    task automatic push_exp(input int p, input bit we, input logic [31:0] rdata);
        exp_t e;
        e.port = p; e.we = we; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Bounded wait for all issued accesses to complete; returns at posedge+2
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
                 !bus.Req0 && !bus.Req1) && n < MAXWAIT) begin
            @(negedge Clk);
            n++;
        end
        chk(n < MAXWAIT, name, 32'(n), 32'(MAXWAIT));
        if (n >= MAXWAIT) begin
            exp_q.delete(); rq0.delete(); rq1.delete();
        end
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #2;
    endtask

    initial begin : main
        int n;
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h04] = 32'hDEAD_BEEF;   // 0x10
        mem[8'h0C] = 32'hCAFE_F00D;   // 0x30

        repeat (3) @(posedge Clk);
        #1;
        chk({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.MemRead, bus.MemWrite} == 6'b0,
            "reset_strobes", 32'({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.MemRead, bus.MemWrite}), 32'h0);
        chk(bus.MemAddress == 32'h0, "reset_addr", bus.MemAddress, 32'h0);
        chk(bus.RData0 == 32'h0 && bus.RData1 == 32'h0, "reset_rdata", bus.RData0 | bus.RData1, 32'h0);
        @(posedge Clk);
        #2 Reset = 1'b0;

        // Tie straight after reset: port 0 first
        push_req(0, 0, 32'h10, 32'h0, 0);
        push_req(1, 0, 32'h30, 32'h0, 0);
        push_exp(0, 0, 32'hDEAD_BEEF);
        push_exp(1, 0, 32'hCAFE_F00D);
        wait_idle("timeout_tie1");

        // Second tie after port 1 was last: port 0 again
        push_req(0, 0, 32'h30, 32'h0, 0);
        push_req(1, 0, 32'h10, 32'h0, 0);
        push_exp(0, 0, 32'hCAFE_F00D);
        push_exp(1, 0, 32'hDEAD_BEEF);
        wait_idle("timeout_tie2");

        // Fairness: both ports requesting back to back for 8 accesses
        push_req(0, 0, 32'h10, 32'h0, 0);
        push_req(0, 0, 32'h30, 32'h0, 0);
        push_req(0, 0, 32'h40, 32'h0, 0);
        push_req(0, 0, 32'h10, 32'h0, 0);
        push_req(1, 1, 32'h40, 32'h55AA_55AA, 0);
        push_req(1, 0, 32'h10, 32'h0, 0);
        push_req(1, 0, 32'h40, 32'h0, 0);
        push_req(1, 0, 32'h30, 32'h0, 0);
        push_exp(0, 0, 32'hDEAD_BEEF);
        push_exp(1, 1, 32'h0);
        push_exp(0, 0, 32'hCAFE_F00D);
        push_exp(1, 0, 32'hDEAD_BEEF);
        push_exp(0, 0, 32'h55AA_55AA);
        push_exp(1, 0, 32'h55AA_55AA);
        push_exp(0, 0, 32'hDEAD_BEEF);
        push_exp(1, 0, 32'hCAFE_F00D);
        wait_idle("timeout_fair");

        // Write from port 1, then read it back on port 0
        push_req(1, 1, 32'h20, 32'h1234_5678, 0);
        push_exp(1, 1, 32'h0);
        wait_idle("timeout_write");
        push_req(0, 0, 32'h20, 32'h0, 0);
        push_exp(0, 0, 32'h1234_5678);
        wait_idle("timeout_readback");

        // Req dropped during BUSY: access still completes, nothing follows
        push_req(0, 0, 32'h10, 32'h0, 1);
        push_exp(0, 0, 32'hDEAD_BEEF);
        wait_idle("timeout_drop");
        repeat (5) @(negedge Clk);
        chk(!bus.Gnt0 && !bus.Gnt1 && !bus.MemRead, "no_reissue",
            32'({bus.Gnt0, bus.Gnt1, bus.MemRead}), 32'h0);

        // Reset in the second BUSY cycle
        @(posedge Clk);
        #2;
        push_req(0, 0, 32'h30, 32'h0, 0);
        push_exp(0, 0, 32'hCAFE_F00D);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!bus.Gnt0 && n < MAXWAIT);
        chk(n < MAXWAIT, "timeout_gnt_mid", 32'(n), 32'(MAXWAIT));
        @(posedge Clk);
        #1;
        chk(bus.Gnt0 && bus.MemRead, "busy2_before_reset", 32'({bus.Gnt0, bus.MemRead}), 32'h3);
        #1 Reset = 1'b1;
        exp_q.delete(); rq0.delete(); rq1.delete();
        #1;
        chk({bus.Gnt0, bus.Gnt1, bus.MemRead, bus.Done0, bus.Done1} == 5'b0, "reset_mid_strobes",
            32'({bus.Gnt0, bus.Gnt1, bus.MemRead, bus.Done0, bus.Done1}), 32'h0);
        chk(bus.RData0 == 32'h0, "reset_mid_rdata0", bus.RData0, 32'h0);
        chk(bus.RData1 == 32'h0, "reset_mid_rdata1", bus.RData1, 32'h0);
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        @(posedge Clk);
        #2;

        // Tie after reset release: port 0 wins again
        push_req(0, 0, 32'h40, 32'h0, 0);
        push_req(1, 0, 32'h30, 32'h0, 0);
        push_exp(0, 0, 32'h55AA_55AA);
        push_exp(1, 0, 32'hCAFE_F00D);
        wait_idle("timeout_tie3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual time %0t", $time);
        $fatal(1);
    end

endmodule
